// File: rtl/guarda_campo_pkg.sv
// ============================================================================
//  Module      : guarda_campo_pkg
//  Description : Shared definitions for the clock/calendar field commit path.
//                Holds the field indices, RTC register addresses, packed-BCD
//                field limits and the sequencer state type. The BCD editor
//                also uses the field and limit constants.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package guarda_campo_pkg;

    // Field indices, as presented on the editor's field select
    localparam logic [3:0] CAMPO_SEG   = 4'd1;
    localparam logic [3:0] CAMPO_MIN   = 4'd2;
    localparam logic [3:0] CAMPO_HORA  = 4'd3;
    localparam logic [3:0] CAMPO_DIA   = 4'd4;
    localparam logic [3:0] CAMPO_MES   = 4'd5;
    localparam logic [3:0] CAMPO_ANIO  = 4'd6;
    localparam logic [3:0] CAMPO_THORA = 4'd7;
    localparam logic [3:0] CAMPO_TMIN  = 4'd8;
    localparam logic [3:0] CAMPO_TSEG  = 4'd9;

    localparam int NUM_CAMPOS = 9;

    // RTC register addresses
    localparam logic [7:0] ADDR_SEG   = 8'h00;
    localparam logic [7:0] ADDR_MIN   = 8'h01;
    localparam logic [7:0] ADDR_HORA  = 8'h02;
    localparam logic [7:0] ADDR_DIA   = 8'h04;
    localparam logic [7:0] ADDR_MES   = 8'h05;
    localparam logic [7:0] ADDR_ANIO  = 8'h06;
    localparam logic [7:0] ADDR_THORA = 8'h42;
    localparam logic [7:0] ADDR_TMIN  = 8'h41;
    localparam logic [7:0] ADDR_TSEG  = 8'h40;

    // Upper limits, packed BCD
    localparam logic [7:0] LIM_SEG   = 8'h59;
    localparam logic [7:0] LIM_MIN   = 8'h59;
    localparam logic [7:0] LIM_HORA  = 8'h23;
    localparam logic [7:0] LIM_DIA   = 8'h31;
    localparam logic [7:0] LIM_MES   = 8'h12;
    localparam logic [7:0] LIM_ANIO  = 8'h99;
    localparam logic [7:0] LIM_THORA = 8'h23;
    localparam logic [7:0] LIM_TMIN  = 8'h59;
    localparam logic [7:0] LIM_TSEG  = 8'h59;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_REQ   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } estado_t;

    function automatic logic campo_valido(input logic [3:0] campo);
        return (campo >= CAMPO_SEG) && (campo <= CAMPO_TSEG);
    endfunction

    function automatic logic [7:0] campo_addr(input logic [3:0] campo);
        logic [7:0] a;
        case (campo)
            CAMPO_SEG:   a = ADDR_SEG;
            CAMPO_MIN:   a = ADDR_MIN;
            CAMPO_HORA:  a = ADDR_HORA;
            CAMPO_DIA:   a = ADDR_DIA;
            CAMPO_MES:   a = ADDR_MES;
            CAMPO_ANIO:  a = ADDR_ANIO;
            CAMPO_THORA: a = ADDR_THORA;
            CAMPO_TMIN:  a = ADDR_TMIN;
            CAMPO_TSEG:  a = ADDR_TSEG;
            default:     a = 8'h00;
        endcase
        return a;
    endfunction

    function automatic logic [7:0] campo_limite(input logic [3:0] campo);
        logic [7:0] l;
        case (campo)
            CAMPO_SEG:   l = LIM_SEG;
            CAMPO_MIN:   l = LIM_MIN;
            CAMPO_HORA:  l = LIM_HORA;
            CAMPO_DIA:   l = LIM_DIA;
            CAMPO_MES:   l = LIM_MES;
            CAMPO_ANIO:  l = LIM_ANIO;
            CAMPO_THORA: l = LIM_THORA;
            CAMPO_TMIN:  l = LIM_TMIN;
            CAMPO_TSEG:  l = LIM_TSEG;
            default:     l = 8'h00;
        endcase
        return l;
    endfunction

endpackage

`default_nettype wire

// File: rtl/guarda_campo_if.sv
// ============================================================================
//  Module      : guarda_campo_if
//  Description : RTC register-bus write port (req/ack handshake).
//                  wr_req_o  master->slave  write request, held until ack
//                  addr_o    master->slave  register address
//                  dato_o    master->slave  BCD data
//                  wr_ack_i  slave->master  write acknowledge
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface guarda_campo_if;
    logic       wr_req_o;
    logic [7:0] addr_o;
    logic [7:0] dato_o;
    logic       wr_ack_i;

    modport master (
        output wr_req_o,
        output addr_o,
        output dato_o,
        input  wr_ack_i
    );

    modport slave (
        input  wr_req_o,
        input  addr_o,
        input  dato_o,
        output wr_ack_i
    );
endinterface

`default_nettype wire

// File: rtl/guarda_campo_valida_bcd.sv
// ============================================================================
//  Module      : valida_bcd
//  Description : Combinational field/value check for the commit sequencer.
//                Maps the field to its RTC address and decides whether the
//                commit may proceed. With GUARDA_VALIDA_EN defined the value
//                itself is checked (BCD digits, field limit, non-zero day and
//                month); otherwise only the field select is checked.
//  Ports       : campo_i  field select (1..9 valid)
//                valor_i  packed BCD value
//                addr_o   RTC register address (0x00 for invalid select)
//                dato_o   value to write
//                ok_o     commit accepted
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module valida_bcd
    import guarda_campo_pkg::*;
(
    input  wire logic [3:0] campo_i,
    input  wire logic [7:0] valor_i,
    output logic      [7:0] addr_o,
    output logic      [7:0] dato_o,
    output logic            ok_o
);

    logic w_sel_ok;

    always_comb begin
        w_sel_ok = campo_valido(campo_i);
        addr_o   = campo_addr(campo_i);
        dato_o   = valor_i;
    end

`ifdef GUARDA_VALIDA_EN
    logic w_nib_ok;
    logic w_rng_ok;
    logic w_cero_ok;

    always_comb begin
        w_nib_ok  = (valor_i[7:4] <= 4'd9) && (valor_i[3:0] <= 4'd9);
        // With both digits valid, packed BCD orders the same as binary,
        // so the limit test is a plain magnitude compare.
        w_rng_ok  = (valor_i <= campo_limite(campo_i));
        w_cero_ok = !(((campo_i == CAMPO_DIA) || (campo_i == CAMPO_MES)) &&
                      (valor_i == 8'h00));
        ok_o      = w_sel_ok && w_nib_ok && w_rng_ok && w_cero_ok;
    end
`else
    always_comb begin
        ok_o = w_sel_ok;
    end
`endif

endmodule

`default_nettype wire

// File: rtl/guarda_campo.sv
// ============================================================================
//  Module      : guarda_campo
//  Description : Commit and write sequencer for the clock/calendar field
//                editor. Latches a field select and packed-BCD value on a
//                commit pulse, validates it, writes it to the RTC over a
//                req/ack bus and keeps a shadow copy of all nine fields.
//                Optional value checking is enabled by GUARDA_VALIDA_EN.
//  Ports       : clk_i      system clock
//                rst_i      asynchronous active-high reset
//                cambio     field select (1..9)
//                valor_i    packed BCD value
//                guardar_i  commit request (sampled in IDLE only)
//                bus        RTC write port (master side)
//                ocupado_o  transaction in progress
//                listo_o    one-cycle pulse, write completed
//                error_o    one-cycle pulse, rejected or timed out
//                campo_o    shadow of field 'cambio' (0x00 if invalid)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module guarda_campo
    import guarda_campo_pkg::*;
#(
    parameter int ESPERA_MAX = 255
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    input  wire logic [3:0]    cambio,
    input  wire logic [7:0]    valor_i,
    input  wire logic          guardar_i,
    guarda_campo_if.master     bus,
    output logic               ocupado_o,
    output logic               listo_o,
    output logic               error_o,
    output logic [7:0]         campo_o
);

    localparam logic [7:0] C_ESPERA_MAX = 8'(ESPERA_MAX);

    estado_t    r_estado;
    logic [3:0] r_campo;
    logic [7:0] r_valor;
    logic [7:0] r_espera;
    logic       r_wr_req;
    logic [7:0] r_addr;
    logic [7:0] r_dato;
    logic       r_ocupado;
    logic       r_listo;
    logic       r_error;
    logic [7:0] r_sombra [NUM_CAMPOS];

    logic [7:0] w_addr;
    logic [7:0] w_dato;
    logic       w_ok;

    // Validation works on the latched copy so input changes after the
    // commit cannot alter the transaction.
    valida_bcd u_valida (
        .campo_i (r_campo),
        .valor_i (r_valor),
        .addr_o  (w_addr),
        .dato_o  (w_dato),
        .ok_o    (w_ok)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_estado  <= ST_IDLE;
            r_campo   <= 4'd0;
            r_valor   <= 8'h00;
            r_espera  <= 8'd0;
            r_wr_req  <= 1'b0;
            r_addr    <= 8'h00;
            r_dato    <= 8'h00;
            r_ocupado <= 1'b0;
            r_listo   <= 1'b0;
            r_error   <= 1'b0;
            for (int i = 0; i < NUM_CAMPOS; i++) begin
                r_sombra[i] <= 8'h00;
            end
        end else begin
            case (r_estado)
                ST_IDLE: begin
                    r_listo <= 1'b0;
                    r_error <= 1'b0;
                    if (guardar_i) begin
                        r_campo   <= cambio;
                        r_valor   <= valor_i;
                        r_ocupado <= 1'b1;
                        r_estado  <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (w_ok) begin
                        r_addr   <= w_addr;
                        r_dato   <= w_dato;
                        r_wr_req <= 1'b1;
                        r_espera <= 8'd0;
                        r_estado <= ST_REQ;
                    end else begin
                        r_error  <= 1'b1;
                        r_estado <= ST_ERR;
                    end
                end

                ST_REQ: begin
                    // An ack wins over the timeout when both land together.
                    if (bus.wr_ack_i) begin
                        r_wr_req <= 1'b0;
                        r_listo  <= 1'b1;
                        for (int i = 0; i < NUM_CAMPOS; i++) begin
                            if (r_campo == 4'(i + 1)) begin
                                r_sombra[i] <= r_dato;
                            end
                        end
                        r_estado <= ST_DONE;
                    end else if (r_espera == C_ESPERA_MAX) begin
                        r_wr_req <= 1'b0;
                        r_error  <= 1'b1;
                        r_estado <= ST_ERR;
                    end else begin
                        r_espera <= r_espera + 8'd1;
                    end
                end

                ST_DONE: begin
                    r_listo   <= 1'b0;
                    r_ocupado <= 1'b0;
                    r_estado  <= ST_IDLE;
                end

                ST_ERR: begin
                    r_error   <= 1'b0;
                    r_ocupado <= 1'b0;
                    r_estado  <= ST_IDLE;
                end

                default: begin
                    r_wr_req  <= 1'b0;
                    r_listo   <= 1'b0;
                    r_error   <= 1'b0;
                    r_ocupado <= 1'b0;
                    r_estado  <= ST_IDLE;
                end
            endcase
        end
    end

    // Shadow read-back follows the live field select
    always_comb begin
        campo_o = 8'h00;
        for (int i = 0; i < NUM_CAMPOS; i++) begin
            if (cambio == 4'(i + 1)) begin
                campo_o = r_sombra[i];
            end
        end
    end

    assign bus.wr_req_o = r_wr_req;
    assign bus.addr_o   = r_addr;
    assign bus.dato_o   = r_dato;
    assign ocupado_o    = r_ocupado;
    assign listo_o      = r_listo;
    assign error_o      = r_error;

endmodule

`default_nettype wire

// File: tb/tb_guarda_campo.sv
// ============================================================================
//  Module      : tb_guarda_campo
//  Description : Self-checking bench for guarda_campo. Directed commits plus
//                randomized commits against a reference model of the field
//                rules (decimal arithmetic on BCD digits, address table and
//                a shadow array).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_guarda_campo;

    localparam int ESPERA = 4;
`ifdef GUARDA_VALIDA_EN
    localparam bit VALIDA = 1'b1;
`else
    localparam bit VALIDA = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] cambio;
    logic [7:0] valor_i;
    logic       guardar_i;
    logic       ocupado_o;
    logic       listo_o;
    logic       error_o;
    logic [7:0] campo_o;

    guarda_campo_if bus ();

    guarda_campo #(.ESPERA_MAX(ESPERA)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cambio    (cambio),
        .valor_i   (valor_i),
        .guardar_i (guardar_i),
        .bus       (bus),
        .ocupado_o (ocupado_o),
        .listo_o   (listo_o),
        .error_o   (error_o),
        .campo_o   (campo_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;
    logic [7:0] sombra [1:9];

    function automatic int dir_de(input int c);
        case (c)
            1: return 'h00;  2: return 'h01;  3: return 'h02;
            4: return 'h04;  5: return 'h05;  6: return 'h06;
            7: return 'h42;  8: return 'h41;  9: return 'h40;
            default: return 0;
        endcase
    endfunction

    function automatic int limite_dec(input int c);
        case (c)
            3, 7:    return 23;
            4:       return 31;
            5:       return 12;
            6:       return 99;
            default: return 59;
        endcase
    endfunction

    function automatic bit modelo_ok(input int c, input int v);
        int  d;
        int  u;
        bit  valor_bien;
        d = v / 16;
        u = v % 16;
        valor_bien = (d <= 9) && (u <= 9) && ((d * 10 + u) <= limite_dec(c)) &&
                     !((c == 4 || c == 5) && v == 0);
        return (c >= 1) && (c <= 9) && (!VALIDA || valor_bien);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_sombras(input string tag);
        for (int c = 0; c < 16; c++) begin
            cambio = 4'(c);
            #1;
            chk($sformatf("%s:campo%0d", tag, c), campo_o,
                (c >= 1 && c <= 9) ? sombra[c] : 8'h00);
        end
    endtask

    // ack_at: REQ cycle index (0 = first) on which ack is given; anything
    // beyond ESPERA means no ack. molesta: re-pulse guardar and scramble
    // inputs while the write is pending.
    task automatic commit(input int c, input logic [7:0] v, input int ack_at,
                          input bit molesta, input string tag);
        bit ok;
        bit acked;
        ok    = modelo_ok(c, int'(v));
        acked = 1'b0;
        chk({tag, ":idle"}, ocupado_o, 8'd0);
        cambio    = 4'(c);
        valor_i   = v;
        guardar_i = 1'b1;
        tick();
        guardar_i = 1'b0;
        cambio    = 4'($urandom);
        valor_i   = 8'($urandom);
        chk({tag, ":chk_busy"}, ocupado_o, 8'd1);
        chk({tag, ":chk_req"}, bus.wr_req_o, 8'd0);
        tick();
        if (!ok) begin
            chk({tag, ":rej_err"}, error_o, 8'd1);
            chk({tag, ":rej_req"}, bus.wr_req_o, 8'd0);
            chk({tag, ":rej_listo"}, listo_o, 8'd0);
            tick();
            chk({tag, ":rej_err_off"}, error_o, 8'd0);
            chk({tag, ":rej_idle"}, ocupado_o, 8'd0);
        end else begin
            for (int i = 0; i <= ESPERA; i++) begin
                chk({tag, ":req"}, bus.wr_req_o, 8'd1);
                chk({tag, ":addr"}, bus.addr_o, 8'(dir_de(c)));
                chk({tag, ":dato"}, bus.dato_o, v);
                chk({tag, ":req_pulsos"}, {6'd0, listo_o, error_o}, 8'd0);
                if (molesta) begin
                    guardar_i = 1'b1;
                    valor_i   = 8'($urandom);
                end
                if (i == ack_at) begin
                    bus.wr_ack_i = 1'b1;
                    tick();
                    bus.wr_ack_i = 1'b0;
                    acked = 1'b1;
                    break;
                end
                tick();
            end
            guardar_i = 1'b0;
            if (acked) begin
                sombra[c] = v;
                chk({tag, ":listo"}, listo_o, 8'd1);
                chk({tag, ":done_req"}, bus.wr_req_o, 8'd0);
                chk({tag, ":done_err"}, error_o, 8'd0);
                cambio = 4'(c);
                #1;
                chk({tag, ":sombra"}, campo_o, v);
                tick();
                chk({tag, ":listo_off"}, listo_o, 8'd0);
                chk({tag, ":done_idle"}, ocupado_o, 8'd0);
            end else begin
                chk({tag, ":to_err"}, error_o, 8'd1);
                chk({tag, ":to_req"}, bus.wr_req_o, 8'd0);
                chk({tag, ":to_listo"}, listo_o, 8'd0);
                tick();
                chk({tag, ":to_err_off"}, error_o, 8'd0);
                chk({tag, ":to_idle"}, ocupado_o, 8'd0);
            end
        end
        chk({tag, ":sin_req"}, bus.wr_req_o, 8'd0);
    endtask

    initial begin
        int c;
        logic [7:0] v;

        rst_i        = 1'b1;
        cambio       = 4'd0;
        valor_i      = 8'h00;
        guardar_i    = 1'b0;
        bus.wr_ack_i = 1'b0;
        for (int i = 1; i <= 9; i++) sombra[i] = 8'h00;

        tick();
        tick();
        chk("rst:req", bus.wr_req_o, 8'd0);
        chk("rst:addr", bus.addr_o, 8'h00);
        chk("rst:dato", bus.dato_o, 8'h00);
        chk("rst:pulsos", {6'd0, listo_o, error_o}, 8'd0);
        chk("rst:ocupado", ocupado_o, 8'd0);
        rst_i = 1'b0;
        tick();
        chk_sombras("rst");

        // Minimum-latency write
        commit(2, 8'h45, 0, 1'b0, "f2_45");
        // Value checks (outcome depends on build)
        commit(3, 8'h24, 0, 1'b0, "f3_24");
        commit(1, 8'h5A, 1, 1'b0, "f1_5a");
        commit(4, 8'h00, 0, 1'b0, "f4_00");
        commit(5, 8'h12, 3, 1'b0, "f5_12");
        // Timeout: no ack at all
        commit(9, 8'h30, ESPERA + 1, 1'b0, "f9_to");
        // Re-pulsed commit and changed value during REQ
        commit(6, 8'h16, 2, 1'b1, "f6_16");
        tick();
        chk("f6_16:no_cola", ocupado_o, 8'd0);
        // Invalid field selects
        commit(0, 8'h11, 0, 1'b0, "f0");
        commit(12, 8'h11, 0, 1'b0, "f12");
        chk_sombras("dir");

        // Ack outside REQ has no effect
        bus.wr_ack_i = 1'b1;
        tick();
        tick();
        chk("ack_idle:req", bus.wr_req_o, 8'd0);
        chk("ack_idle:pulsos", {6'd0, listo_o, error_o}, 8'd0);
        chk("ack_idle:ocupado", ocupado_o, 8'd0);
        bus.wr_ack_i = 1'b0;

        // Randomized commits
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) c = int'($urandom_range(0, 15));
            else                           c = int'($urandom_range(1, 9));
            if ($urandom_range(0, 1) == 0) v = 8'($urandom);
            else v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            commit(c, v, int'($urandom_range(0, ESPERA + 1)),
                   1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
        end
        chk_sombras("rnd");

        // Reset while a write is pending
        commit(7, 8'h21, 0, 1'b0, "f7_pre");
        cambio    = 4'd1;
        valor_i   = 8'h30;
        guardar_i = 1'b1;
        tick();
        guardar_i = 1'b0;
        tick();
        chk("rst_req:req_antes", bus.wr_req_o, 8'd1);
        rst_i = 1'b1;
        #1;
        chk("rst_req:req", bus.wr_req_o, 8'd0);
        chk("rst_req:ocupado", ocupado_o, 8'd0);
        chk("rst_req:pulsos", {6'd0, listo_o, error_o}, 8'd0);
        tick();
        rst_i = 1'b0;
        for (int i = 1; i <= 9; i++) sombra[i] = 8'h00;
        tick();
        chk("rst_req:pulsos_post", {6'd0, listo_o, error_o}, 8'd0);
        chk_sombras("rst_req");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
